// File: rtl/unit_sram_banked_cfg_pkg.sv
// sram_cfg_pkg: shared definitions for the banked, width-configurable SRAM.
//   - conf encodings (32b / 16b / 8b, reserved code behaves as 32b)
//   - width_from_conf, lane_mask, lane_shift: address/lane helpers
//   - wmask_gen: byte write mask for a given width and lane
//   - rd_tag_t: read sideband carried down the pipeline with each read
//   - MACRO_AW_DEF: word-address width of one 256x32 macro
package sram_cfg_pkg;

  localparam int MACRO_AW_DEF = 8;

  localparam logic [1:0] CONF_32  = 2'b00;
  localparam logic [1:0] CONF_16  = 2'b01;
  localparam logic [1:0] CONF_8   = 2'b10;
  localparam logic [1:0] CONF_RSV = 2'b11;

  typedef struct packed {
    logic       oreg;
    logic [1:0] conf;
    logic [1:0] lane;
  } rd_tag_t;

  function automatic logic [5:0] width_from_conf(input logic [1:0] conf);
    case (conf)
      CONF_16: return 6'd16;
      CONF_8:  return 6'd8;
      default: return 6'd32;
    endcase
  endfunction

  // Address bits that select the lane inside a 32-bit word.
  function automatic logic [1:0] lane_mask(input logic [1:0] conf);
    case (conf)
      CONF_16: return 2'b01;
      CONF_8:  return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // Number of lane bits below the word address (clog2(32/W)).
  function automatic logic [1:0] lane_shift(input logic [1:0] conf);
    case (conf)
      CONF_16: return 2'd1;
      CONF_8:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [3:0] wmask_gen(input logic [1:0] conf, input logic [1:0] lane);
    case (conf)
      CONF_16: return lane[0] ? 4'b1100 : 4'b0011;
      CONF_8:  return 4'b0001 << lane;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/unit_sram_banked_cfg_if.sv
// unit_sram_banked_cfg_if: fabric-side request/response bundle.
//   csb/web/reb      active-low chip select, write enable, read enable
//   addr_w/addr_r    write/read addresses in units of the configured width
//   d_fabric_in      write data (low W bits used)
//   conf, out_reg    width mode and registered-output select, per request
//   d_fabric_out     read data, zero-extended above W
//   rd_valid         one-cycle pulse per completed read
interface unit_sram_banked_cfg_if #(
  parameter int AW = 12
);
  logic          csb;
  logic          web;
  logic          reb;
  logic [AW-1:0] addr_w;
  logic [AW-1:0] addr_r;
  logic [31:0]   d_fabric_in;
  logic [1:0]    conf;
  logic          out_reg;
  logic [31:0]   d_fabric_out;
  logic          rd_valid;

  modport master (
    output csb, web, reb, addr_w, addr_r, d_fabric_in, conf, out_reg,
    input  d_fabric_out, rd_valid
  );

  modport slave (
    input  csb, web, reb, addr_w, addr_r, d_fabric_in, conf, out_reg,
    output d_fabric_out, rd_valid
  );
endinterface

// File: rtl/sram_1rw1r_32_256_8_sky130.sv
// sram_1rw1r_32_256_8_sky130: behavioural stand-in for the 256x32 1RW+1R macro.
//   port 0 (clk0/csb0/web0/wmask0/addr0/din0/dout0): byte-masked write or read
//   port 1 (clk1/csb1/addr1/dout1): read only
// A port-1 read on the same edge as a port-0 write to that word returns the
// old contents; the wrapper above never relies on that case.
module sram_1rw1r_32_256_8_sky130 (
  input  logic        clk0,
  input  logic        csb0,
  input  logic        web0,
  input  logic [3:0]  wmask0,
  input  logic [7:0]  addr0,
  input  logic [31:0] din0,
  output logic [31:0] dout0,
  input  logic        clk1,
  input  logic        csb1,
  input  logic [7:0]  addr1,
  output logic [31:0] dout1
);
  logic [31:0] mem [256];

  always_ff @(posedge clk0) begin
    if (!csb0 && !web0) begin
      for (int i = 0; i < 4; i++)
        if (wmask0[i]) mem[addr0][i*8 +: 8] <= din0[i*8 +: 8];
    end
    if (!csb0 && web0) dout0 <= mem[addr0];
  end

  always_ff @(posedge clk1) begin
    if (!csb1) dout1 <= mem[addr1];
  end
endmodule

// File: rtl/unit_sram_banked_cfg_align.sv
// sram_lane_align: combinational lane handling for both directions.
//   wr_*: replicate the low W bits of wr_din across 32 bits and build the
//         byte mask for the addressed lane
//   rd_*: pick lane rd_lane out of rd_word and zero-extend to 32 bits
module sram_lane_align
  import sram_cfg_pkg::*;
(
  input  logic [1:0]  wr_conf,
  input  logic [1:0]  wr_lane,
  input  logic [31:0] wr_din,
  output logic [31:0] wr_data,
  output logic [3:0]  wr_mask,
  input  logic [1:0]  rd_conf,
  input  logic [1:0]  rd_lane,
  input  logic [31:0] rd_word,
  output logic [31:0] rd_data
);
  logic [31:0] rd_shift;

  always_comb begin
    wr_mask = wmask_gen(wr_conf, wr_lane);
    case (wr_conf)
      CONF_16: wr_data = {2{wr_din[15:0]}};
      CONF_8:  wr_data = {4{wr_din[7:0]}};
      default: wr_data = wr_din;
    endcase
  end

  always_comb begin
    rd_shift = rd_word >> {rd_lane, 3'b000};
    case (rd_conf)
      CONF_16: rd_data = {16'h0, (rd_lane[0] ? rd_word[31:16] : rd_word[15:0])};
      CONF_8:  rd_data = {24'h0, rd_shift[7:0]};
      default: rd_data = rd_word;
    endcase
  end
endmodule

// File: rtl/unit_sram_banked_cfg.sv
// unit_sram_banked_cfg: NUM_BANKS x (256x32) SRAM with 32/16/8-bit access.
//   clk   single clock for the pipeline and every macro port
//   rstb  synchronous active-low reset
//   bus   fabric request/response bundle (slave side)
// Pipeline: S1 registers the request, S2 is the macro access edge (only the
// addressed bank is selected), S3 captures the selected bank's word (merged
// with same-edge write data on a collision), optional output register after.
module unit_sram_banked_cfg
  import sram_cfg_pkg::*;
#(
  parameter int NUM_BANKS = 4,
  parameter int MACRO_AW  = MACRO_AW_DEF
) (
  input  logic                 clk,
  input  logic                 rstb,
  unit_sram_banked_cfg_if.slave bus
);
  localparam int BB = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0;
  localparam int BW = (BB > 0) ? BB : 1;
  localparam int AW = MACRO_AW + BB + 2;
  localparam logic [BW-1:0] BANK_MASK = BW'(NUM_BANKS - 1);

  // S1
  logic          s1_wr;
  logic [1:0]    s1_conf;
  logic          s1_oreg;
  logic [AW-1:0] s1_aw, s1_ar;
  logic [31:0]   s1_din;
  // read valid per stage: [0]=S1, [1]=S2, [2]=S3
  logic [2:0]    vld_pipe;

  // decoded S1 addresses
  logic [1:0]          w_lane, r_lane;
  logic [MACRO_AW-1:0] w_word, r_word;
  logic [BW-1:0]       w_bank, r_bank;
  logic                col;

  // S2 / S3 / output
  rd_tag_t       s2_tag, s3_tag;
  logic [BW-1:0] s2_bank;
  logic          s2_col;
  logic [3:0]    s2_cmask;
  logic [31:0]   s2_cdata;
  logic [31:0]   s3_word;
  logic [31:0]   dout_q;
  logic          dout_vld;

  logic [31:0] wr_data, rd_merged, rd_ext;
  logic [3:0]  wr_mask;

  logic [NUM_BANKS-1:0]       csb0, csb1;
  logic [NUM_BANKS-1:0][31:0] dout1;
  logic [NUM_BANKS-1:0][31:0] unused_dout0;

  // Bank field is masked to the instantiated range, so every address maps
  // to a real bank.
  always_comb begin
    w_lane = s1_aw[1:0] & lane_mask(s1_conf);
    r_lane = s1_ar[1:0] & lane_mask(s1_conf);
    w_word = MACRO_AW'(s1_aw >> lane_shift(s1_conf));
    r_word = MACRO_AW'(s1_ar >> lane_shift(s1_conf));
    w_bank = BW'(s1_aw >> (MACRO_AW + int'(lane_shift(s1_conf)))) & BANK_MASK;
    r_bank = BW'(s1_ar >> (MACRO_AW + int'(lane_shift(s1_conf)))) & BANK_MASK;
    col    = s1_wr && vld_pipe[0] && (w_bank == r_bank) && (w_word == r_word);
  end

  sram_lane_align u_align (
    .wr_conf (s1_conf),
    .wr_lane (w_lane),
    .wr_din  (s1_din),
    .wr_data (wr_data),
    .wr_mask (wr_mask),
    .rd_conf (s3_tag.conf),
    .rd_lane (s3_tag.lane),
    .rd_word (s3_word),
    .rd_data (rd_ext)
  );

  // The macro returns pre-write data on a same-edge collision; patch the
  // written bytes in from the write that was captured alongside the read.
  always_comb begin
    rd_merged = dout1[s2_bank];
    for (int i = 0; i < 4; i++)
      if (s2_col && s2_cmask[i]) rd_merged[i*8 +: 8] = s2_cdata[i*8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      s1_wr    <= 1'b0;
      s1_conf  <= CONF_32;
      s1_oreg  <= 1'b0;
      s1_aw    <= '0;
      s1_ar    <= '0;
      s1_din   <= '0;
      vld_pipe <= '0;
      s2_tag   <= '0;
      s2_bank  <= '0;
      s2_col   <= 1'b0;
      s2_cmask <= '0;
      s2_cdata <= '0;
      s3_tag   <= '0;
      s3_word  <= '0;
      dout_q   <= '0;
      dout_vld <= 1'b0;
    end else begin
      s1_wr    <= !bus.csb && !bus.web;
      vld_pipe <= {vld_pipe[1:0], (!bus.csb && !bus.reb)};
      s1_conf  <= bus.conf;
      s1_oreg  <= bus.out_reg;
      s1_aw    <= bus.addr_w;
      s1_ar    <= bus.addr_r;
      s1_din   <= bus.d_fabric_in;

      s2_tag.oreg <= s1_oreg;
      s2_tag.conf <= s1_conf;
      s2_tag.lane <= r_lane;
      s2_bank     <= r_bank;
      s2_col      <= col;
      s2_cmask    <= wr_mask;
      s2_cdata    <= wr_data;

      s3_tag  <= s2_tag;
      s3_word <= rd_merged;

      dout_vld <= vld_pipe[2] && s3_tag.oreg;
      if (vld_pipe[2] && s3_tag.oreg) dout_q <= rd_ext;
    end
  end

  // A read with out_reg=0 directly following one with out_reg=1 lands in
  // the same cycle; the registered result wins the data bus.
  assign bus.rd_valid     = (vld_pipe[2] && !s3_tag.oreg) || dout_vld;
  assign bus.d_fabric_out = (vld_pipe[2] && !s3_tag.oreg && !dout_vld) ? rd_ext : dout_q;

  // Selects are gated by rstb so no macro access happens on a reset edge.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign csb0[b] = !(rstb && s1_wr && (w_bank == BW'(b)));
    assign csb1[b] = !(rstb && vld_pipe[0] && (r_bank == BW'(b)));

    sram_1rw1r_32_256_8_sky130 u_sram (
      .clk0   (clk),
      .csb0   (csb0[b]),
      .web0   (1'b0),
      .wmask0 (wr_mask),
      .addr0  (w_word),
      .din0   (wr_data),
      .dout0  (unused_dout0[b]),
      .clk1   (clk),
      .csb1   (csb1[b]),
      .addr1  (r_word),
      .dout1  (dout1[b])
    );
  end
endmodule

// File: tb/tb_unit_sram_banked_cfg.sv
// tb_unit_sram_banked_cfg: directed bench for unit_sram_banked_cfg with
// default parameters (4 banks, 12-bit addresses). Inputs change 1 time unit
// after a rising edge; outputs are sampled at the same point.
module tb_unit_sram_banked_cfg;
  import sram_cfg_pkg::*;

  logic clk = 1'b0;
  logic rstb;
  int   passed = 0;
  int   failed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  unit_sram_banked_cfg_if #(.AW(12)) bus ();

  unit_sram_banked_cfg #(.NUM_BANKS(4), .MACRO_AW(8)) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.csb = 1'b1;
    bus.web = 1'b1;
    bus.reb = 1'b1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [1:0] c);
    bus.conf        = c;
    bus.csb         = 1'b0;
    bus.web         = 1'b0;
    bus.addr_w      = a;
    bus.d_fabric_in = d;
    tick();
    idle();
  endtask

  // Issue one read (optionally with a same-edge write already set up by the
  // caller), then wait a bounded number of edges for rd_valid.
  task automatic rd(input string tag, input logic [11:0] a, input logic [1:0] c,
                    input logic oreg, input logic [31:0] exp);
    int n;
    bus.conf    = c;
    bus.out_reg = oreg;
    bus.csb     = 1'b0;
    bus.reb     = 1'b0;
    bus.addr_r  = a;
    tick();
    idle();
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.rd_valid && n < 6);
    chk({tag, "_lat"}, 32'(n), oreg ? 32'd3 : 32'd2);
    chk({tag, "_data"}, bus.d_fabric_out, exp);
  endtask

  logic [31:0] bexp [4];
  logic        seen;

  initial begin
    rstb            = 1'b0;
    bus.conf        = CONF_32;
    bus.out_reg     = 1'b0;
    bus.addr_w      = '0;
    bus.addr_r      = '0;
    bus.d_fabric_in = '0;
    idle();
    repeat (3) tick();

    // reset state
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_dout", bus.d_fabric_out, 32'h0);
    chk("rst_csb", 32'({dut.csb0, dut.csb1}), 32'hFF);

    // first edge with rstb=1 takes the write; read right after sees it
    rstb = 1'b1;
    wr(12'h3FF, 32'hDEADBEEF, CONF_32);
    rd("w32", 12'h3FF, CONF_32, 1'b0, 32'hDEADBEEF);
    tick();
    chk("w32_pulse_once", 32'(bus.rd_valid), 32'd0);

    // 8-bit writes with junk above bit 7, then wider reads
    wr(12'h000, 32'hFFFFFF11, CONF_8);
    wr(12'h001, 32'hFFFFFF22, CONF_8);
    wr(12'h002, 32'hFFFFFF33, CONF_8);
    wr(12'h003, 32'hFFFFFF44, CONF_8);
    rd("b8_as32", 12'h000, CONF_32, 1'b0, 32'h44332211);
    rd("b8_as16", 12'h001, CONF_16, 1'b0, 32'h00004433);
    rd("b8_as8", 12'h002, CONF_8, 1'b0, 32'h00000033);

    // same-edge collision: 16-bit lane 1 of word 0x10 in bank 0
    wr(12'h010, 32'hAAAAAAAA, CONF_32);
    bus.web         = 1'b0;
    bus.addr_w      = 12'h021;
    bus.d_fabric_in = 32'h00001234;
    rd("col16", 12'h021, CONF_16, 1'b0, 32'h00001234);
    rd("col_after32", 12'h010, CONF_32, 1'b0, 32'h1234AAAA);
    rd("col_lane0", 12'h020, CONF_16, 1'b0, 32'h0000AAAA);

    // out_reg=1, back-to-back reads of all four banks
    wr(12'h0FF, 32'hB0B00000, CONF_32);
    wr(12'h1FF, 32'hB0B00001, CONF_32);
    wr(12'h2FF, 32'hB0B00002, CONF_32);
    bexp[0] = 32'hB0B00000;
    bexp[1] = 32'hB0B00001;
    bexp[2] = 32'hB0B00002;
    bexp[3] = 32'hDEADBEEF;
    bus.out_reg = 1'b1;
    bus.conf    = CONF_32;
    for (int c = 0; c < 9; c++) begin
      if (c < 4) begin
        bus.csb    = 1'b0;
        bus.reb    = 1'b0;
        bus.addr_r = 12'(c * 256 + 255);
      end else begin
        idle();
      end
      tick();
      chk($sformatf("b2b_vld_c%0d", c), 32'(bus.rd_valid), 32'((c >= 3) && (c <= 6)));
      if (c >= 3) chk($sformatf("b2b_data_c%0d", c), bus.d_fabric_out, bexp[(c > 6) ? 3 : c - 3]);
    end

    // reset one cycle after a read and a write: both discarded
    bus.out_reg     = 1'b0;
    bus.conf        = CONF_32;
    bus.csb         = 1'b0;
    bus.web         = 1'b0;
    bus.reb         = 1'b0;
    bus.addr_w      = 12'h0FF;
    bus.d_fabric_in = 32'h55555555;
    bus.addr_r      = 12'h1FF;
    tick();
    idle();
    rstb = 1'b0;
    tick();
    chk("midrst_csb", 32'({dut.csb0, dut.csb1}), 32'hFF);
    tick();
    chk("midrst_dout", bus.d_fabric_out, 32'h0);
    rstb = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen = seen | bus.rd_valid;
    end
    chk("midrst_no_valid", 32'(seen), 32'd0);
    rd("midrst_prewrite", 12'h0FF, CONF_32, 1'b0, 32'hB0B00000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
